// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and widths for the dot-product accumulator and its multiplier.
package dot_product_accumulator_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/dot_product_accumulator_wallace.sv
// Combinational 8x8 unsigned multiplier: partial products are folded through a
// chain of 3:2 carry-save compressors and resolved by one final carry-propagate add.
module wallace
    import dot_product_accumulator_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] sum_s;
    logic [PROD_W-1:0] carry_s;
    logic [PROD_W-1:0] pp_s;
    logic [PROD_W-1:0] nsum_s;
    logic [PROD_W-1:0] ncarry_s;

    // Carry-save reduction of the eight partial products, then the final add.
    always_comb begin
        sum_s    = '0;
        carry_s  = '0;
        pp_s     = '0;
        nsum_s   = '0;
        ncarry_s = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i]) begin
                pp_s = {{(PROD_W-OP_W){1'b0}}, a} << i;
            end else begin
                pp_s = '0;
            end
            nsum_s   = sum_s ^ carry_s ^ pp_s;
            ncarry_s = ((sum_s & carry_s) | (sum_s & pp_s) | (carry_s & pp_s)) << 1;
            sum_s    = nsum_s;
            carry_s  = ncarry_s;
        end
        p = sum_s + carry_s;
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates LEN unsigned 8x8 products per vector and presents the sum on a
// valid/ready output; clears itself once the result is taken.
module dot_product_accumulator
    import dot_product_accumulator_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 19
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a_in,
    input  logic [OP_W-1:0]  b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    state_e             state_r;
    logic [CNT_W-1:0]   acc_cnt_r;
    logic [CNT_W-1:0]   done_cnt_r;
    logic [OP_W-1:0]    op_a_r;
    logic [OP_W-1:0]    op_b_r;
    logic               s1_valid_r;
    logic [ACC_W-1:0]   acc_r;
    logic               ovf_r;

    logic [PROD_W-1:0]  prod_s;
    logic [ACC_W:0]     sum_ext_s;
    logic               in_hs_s;

    wallace u_wallace (
        .a (op_a_r),
        .b (op_b_r),
        .p (prod_s)
    );

    // Outputs are forced low while reset is asserted so nothing stale escapes.
    assign in_ready  = (state_r == ACCUM) && (acc_cnt_r < LEN_C) && !rst;
    assign out_valid = (state_r == HOLD) && !rst;
    assign out_sum   = rst ? '0 : acc_r;
    assign out_ovf   = rst ? 1'b0 : ovf_r;
    assign in_hs_s   = in_valid && in_ready;

    // Accumulator adder with one extra bit to expose the carry-out.
    always_comb begin
        sum_ext_s = {1'b0, acc_r} + {{(ACC_W+1-PROD_W){1'b0}}, prod_s};
    end

    // Operand capture, stage-2 accumulation and the ACCUM/HOLD control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ACCUM;
            acc_cnt_r  <= '0;
            done_cnt_r <= '0;
            op_a_r     <= '0;
            op_b_r     <= '0;
            s1_valid_r <= 1'b0;
            acc_r      <= '0;
            ovf_r      <= 1'b0;
        end else begin
            if (in_hs_s) begin
                op_a_r     <= a_in;
                op_b_r     <= b_in;
                s1_valid_r <= 1'b1;
                acc_cnt_r  <= acc_cnt_r + 8'd1;
            end else begin
                s1_valid_r <= 1'b0;
            end
            case (state_r)
                ACCUM: begin
                    if (s1_valid_r) begin
                        acc_r      <= sum_ext_s[ACC_W-1:0];
                        ovf_r      <= ovf_r | sum_ext_s[ACC_W];
                        done_cnt_r <= done_cnt_r + 8'd1;
                        if ((done_cnt_r + 8'd1) == LEN_C) begin
                            state_r <= HOLD;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                HOLD: begin
                    // Input is blocked in HOLD, so clearing acc_cnt here never
                    // collides with the increment above.
                    if (out_ready) begin
                        acc_r      <= '0;
                        ovf_r      <= 1'b0;
                        acc_cnt_r  <= '0;
                        done_cnt_r <= '0;
                        state_r    <= ACCUM;
                    end else begin
                        state_r    <= HOLD;
                    end
                end
                default: begin
                    state_r <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed and randomised checks of dot_product_accumulator (default build and
// a narrow ACC_W=16, LEN=2 build exercising overflow).
module tb_dot_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [7:0]  a_in, b_in;
    logic [18:0] out_sum;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_ovf;
    logic [7:0]  w_a, w_b;
    logic [15:0] w_out_sum;

    int total = 0;
    int bad   = 0;

    logic [7:0] va [8];
    logic [7:0] vb [8];

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [18:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    dot_product_accumulator #(.LEN(8), .ACC_W(19)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    dot_product_accumulator #(.LEN(2), .ACC_W(16)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .a_in      (w_a),
        .b_in      (w_b),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_sum   (w_out_sum),
        .out_ovf   (w_out_ovf)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sends va/vb as one vector; returns the result and the accept-to-valid distance.
    task automatic drive_vec(input int gap_pct, input int rdy_pct,
                             output logic [18:0] s, output logic o,
                             output int lat, output bit ok);
        int  i = 0;
        bit  pend = 1'b0;
        int  cyc = 0;
        int  last_acc = -1;
        int  first_valid = -1;
        bit  acc_now, done_now;
        s  = '0;
        o  = 1'b0;
        ok = 1'b0;
        while (!ok && cyc < 3000) begin
            if (i < 8) begin
                if (!pend && $urandom_range(99) >= gap_pct) pend = 1'b1;
                in_valid = pend;
                a_in = va[i];
                b_in = vb[i];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            if (out_valid && first_valid < 0) first_valid = cyc;
            acc_now  = in_valid && in_ready;
            done_now = out_valid && out_ready;
            if (done_now) begin
                s = out_sum;
                o = out_ovf;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                i++;
                pend = 1'b0;
                last_acc = cyc;
            end
            if (done_now) ok = 1'b1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lat = first_valid - last_acc;
    endtask

    // Sends (a,b) x2 to the narrow instance and collects its result.
    task automatic run_w(input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] s, output logic o, output bit ok);
        int n = 0;
        int cyc = 0;
        bit acc_now, done_now;
        s = '0;
        o = 1'b0;
        ok = 1'b0;
        w_in_valid  = 1'b1;
        w_a         = a;
        w_b         = b;
        w_out_ready = 1'b1;
        while (!ok && cyc < 100) begin
            acc_now  = w_in_valid && w_in_ready;
            done_now = w_out_valid && w_out_ready;
            if (done_now) begin
                s = w_out_sum;
                o = w_out_ovf;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                n++;
                if (n == 2) w_in_valid = 1'b0;
            end
            if (done_now) ok = 1'b1;
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b0;
    endtask

    initial begin
        logic [18:0] s;
        logic        o;
        logic [15:0] ws;
        logic        wo;
        int          lat;
        bit          ok;
        logic [18:0] gold;
        int          wcyc;

        tbl[0] = '{8'd1,   8'd1,   19'd8,      1'b0};
        tbl[1] = '{8'd255, 8'd255, 19'd520200, 1'b0};
        tbl[2] = '{8'd3,   8'd5,   19'd120,    1'b0};
        tbl[3] = '{8'd2,   8'd2,   19'd32,     1'b0};
        tbl[4] = '{8'd0,   8'd255, 19'd0,      1'b0};
        tbl[5] = '{8'd255, 8'd1,   19'd2040,   1'b0};
        tbl[6] = '{8'd16,  8'd16,  19'd2048,   1'b0};
        tbl[7] = '{8'd200, 8'd7,   19'd11200,  1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a_in = 8'd0; b_in = 8'd0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = 8'd0; w_b = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready",  in_ready,  0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_sum",   out_sum,   0);
        chk("reset out_ovf",   out_ovf,   0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready, 1);

        // Table: back-to-back vectors, consumer always ready.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 8; k++) begin
                va[k] = tbl[t].a;
                vb[k] = tbl[t].b;
            end
            drive_vec(0, 100, s, o, lat, ok);
            chk($sformatf("tbl%0d done", t), ok, 1);
            chk($sformatf("tbl%0d sum", t), s, tbl[t].exp_sum);
            chk($sformatf("tbl%0d ovf", t), o, tbl[t].exp_ovf);
            chk($sformatf("tbl%0d latency", t), lat, 1);
        end

        // Backpressure: (3,5)x8 held for 5 cycles with stray in_valid pulses.
        for (int k = 0; k < 8; k++) begin
            va[k] = 8'd3;
            vb[k] = 8'd5;
        end
        drive_vec(0, 0, s, o, lat, ok);
        chk("bp timeout expected", ok, 0);
        chk("bp out_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid  = c[0];
            a_in      = 8'd99;
            b_in      = 8'd99;
            chk($sformatf("bp sum c%0d", c), out_sum, 120);
            chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
            chk($sformatf("bp valid c%0d", c), out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp sum final", out_sum, 120);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp after hs valid", out_valid, 0);
        chk("bp after hs in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            va[k] = 8'd2;
            vb[k] = 8'd2;
        end
        drive_vec(0, 100, s, o, lat, ok);
        chk("bp next sum", s, 32);

        // Reset after 3 of 8 pairs accepted.
        in_valid = 1'b1; a_in = 8'd7; b_in = 8'd7;
        wcyc = 0;
        for (int n = 0; n < 3 && wcyc < 20; wcyc++) begin
            if (in_ready) n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst in_ready",  in_ready,  0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out_sum",   out_sum,   0);
        chk("midrst out_ovf",   out_ovf,   0);
        @(posedge clk); #1;
        chk("midrst2 in_ready", in_ready, 0);
        chk("midrst2 out_sum",  out_sum,  0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            va[k] = 8'd10;
            vb[k] = 8'd10;
        end
        drive_vec(0, 100, s, o, lat, ok);
        chk("after rst sum", s, 800);
        chk("after rst ovf", o, 0);

        // Random operands, random input gaps and consumer stalls.
        for (int v = 0; v < 1000; v++) begin
            gold = '0;
            for (int k = 0; k < 8; k++) begin
                va[k] = 8'($urandom_range(255));
                vb[k] = 8'($urandom_range(255));
                gold  = gold + 19'(va[k]) * 19'(vb[k]);
            end
            drive_vec(25, 50, s, o, lat, ok);
            if (!ok) begin
                chk($sformatf("rand%0d timeout", v), ok, 1);
            end else begin
                chk($sformatf("rand%0d sum", v), s, gold);
            end
        end

        // Narrow build: overflow on (255,255)x2, then clean (1,1)x2.
        run_w(8'd255, 8'd255, ws, wo, ok);
        chk("w done", ok, 1);
        chk("w ovf sum", ws, 64514);
        chk("w ovf flag", wo, 1);
        run_w(8'd1, 8'd1, ws, wo, ok);
        chk("w next sum", ws, 2);
        chk("w next ovf", wo, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
